// File: rtl/regfile_write_arbiter_if.sv
// Request and register-file write bus shared by the two writers and the arbiter.
interface regfile_write_arbiter_if #(
    parameter int unsigned AW   = 2,
    parameter int unsigned DW   = 8,
    parameter int unsigned NREG = 4
);
    logic            a_valid;
    logic            a_ready;
    logic [AW-1:0]   a_reg;
    logic [DW-1:0]   a_data;
    logic            b_valid;
    logic            b_ready;
    logic [AW-1:0]   b_reg;
    logic [DW-1:0]   b_data;
    logic [AW-1:0]   writereg;
    logic [DW-1:0]   wdata;
    logic            regwrite;
    logic [NREG-1:0] busy;
    logic            last_grant;

    modport master (
        output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        input  a_ready, b_ready, writereg, wdata, regwrite, busy, last_grant
    );

    modport slave (
        input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        output a_ready, b_ready, writereg, wdata, regwrite, busy, last_grant
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between two buffered writers.
// Optional REGARB_STATS_EN adds a saturating conflict_count output.
module regfile_write_arbiter #(
    parameter int unsigned AW   = 2,
    parameter int unsigned DW   = 8,
    parameter int unsigned NREG = 4
) (
    input  logic clk,
    input  logic rst,
    regfile_write_arbiter_if.slave bus
`ifdef REGARB_STATS_EN
    ,
    output logic [7:0] conflict_count
`endif
);
    localparam int unsigned CNT_W = 8;

    logic          full_a_q, full_a_d, full_b_q, full_b_d;
    logic [AW-1:0] reg_a_q, reg_a_d, reg_b_q, reg_b_d;
    logic [DW-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
    logic [AW-1:0] writereg_q, writereg_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          regwrite_q, regwrite_d;
    logic          last_grant_q, last_grant_d;

    logic            grant_a_c, grant_b_c, acc_a_c, acc_b_c;
    logic [NREG-1:0] busy_c;

    // On a tie the requester that did not win last time gets the port.
    assign grant_a_c = full_a_q & (~full_b_q | last_grant_q);
    assign grant_b_c = full_b_q & (~full_a_q | ~last_grant_q);

    assign bus.a_ready = ~full_a_q | grant_a_c;
    assign bus.b_ready = ~full_b_q | grant_b_c;
    assign acc_a_c     = bus.a_valid & bus.a_ready;
    assign acc_b_c     = bus.b_valid & bus.b_ready;

    always_comb begin
        full_a_d     = full_a_q;
        full_b_d     = full_b_q;
        reg_a_d      = reg_a_q;
        reg_b_d      = reg_b_q;
        data_a_d     = data_a_q;
        data_b_d     = data_b_q;
        writereg_d   = writereg_q;
        wdata_d      = wdata_q;
        regwrite_d   = 1'b0;
        last_grant_d = last_grant_q;

        if (grant_a_c) begin
            writereg_d   = reg_a_q;
            wdata_d      = data_a_q;
            regwrite_d   = 1'b1;
            last_grant_d = 1'b0;
            full_a_d     = 1'b0;
        end else if (grant_b_c) begin
            writereg_d   = reg_b_q;
            wdata_d      = data_b_q;
            regwrite_d   = 1'b1;
            last_grant_d = 1'b1;
            full_b_d     = 1'b0;
        end

        // A same-cycle accept refills a buffer that is draining this edge.
        if (acc_a_c) begin
            full_a_d = 1'b1;
            reg_a_d  = bus.a_reg;
            data_a_d = bus.a_data;
        end
        if (acc_b_c) begin
            full_b_d = 1'b1;
            reg_b_d  = bus.b_reg;
            data_b_d = bus.b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_a_q     <= 1'b0;
            full_b_q     <= 1'b0;
            reg_a_q      <= '0;
            reg_b_q      <= '0;
            data_a_q     <= '0;
            data_b_q     <= '0;
            writereg_q   <= '0;
            wdata_q      <= '0;
            regwrite_q   <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            full_a_q     <= full_a_d;
            full_b_q     <= full_b_d;
            reg_a_q      <= reg_a_d;
            reg_b_q      <= reg_b_d;
            data_a_q     <= data_a_d;
            data_b_q     <= data_b_d;
            writereg_q   <= writereg_d;
            wdata_q      <= wdata_d;
            regwrite_q   <= regwrite_d;
            last_grant_q <= last_grant_d;
        end
    end

    // A register stays busy from buffer capture until its write is on the port.
    always_comb begin
        busy_c = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            busy_c[r] = (full_a_q & (reg_a_q == AW'(r)))
                      | (full_b_q & (reg_b_q == AW'(r)))
                      | (regwrite_q & (writereg_q == AW'(r)));
        end
    end

    assign bus.busy       = busy_c;
    assign bus.writereg   = writereg_q;
    assign bus.wdata      = wdata_q;
    assign bus.regwrite   = regwrite_q;
    assign bus.last_grant = last_grant_q;

`ifdef REGARB_STATS_EN
    logic [CNT_W-1:0] conflict_q, conflict_d;

    always_comb begin
        conflict_d = conflict_q;
        if (full_a_q && full_b_q && (conflict_q != {CNT_W{1'b1}})) begin
            conflict_d = conflict_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= '0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict_count = conflict_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised and directed bench for regfile_write_arbiter against a transaction-level model.
module tb_regfile_write_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    regfile_write_arbiter_if #(.AW(2), .DW(8), .NREG(4)) bus ();
`ifdef REGARB_STATS_EN
    logic [7:0] conflict_count;
`endif

    regfile_write_arbiter #(.AW(2), .DW(8), .NREG(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef REGARB_STATS_EN
        ,
        .conflict_count (conflict_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed register file and write count, built from the DUT's write port.
    logic [7:0] rf_obs [4];
    int         wr_count;
    initial wr_count = 0;
    always @(posedge clk) begin
        if (bus.regwrite) begin
            rf_obs[bus.writereg] <= bus.wdata;
            wr_count             <= wr_count + 1;
        end
    end

    // Model: index 0 is requester A, 1 is requester B.
    bit         mf [2];
    logic [1:0] mr [2];
    logic [7:0] md [2];
    bit         mlast;
    bit         mwe;
    logic [1:0] mwr;
    logic [7:0] mwd;
    int         mcnt;
    int         acc_total;
    bit         acc_a, acc_b;

    function automatic int winner();
        if (mf[0] && mf[1]) return mlast ? 0 : 1;
        if (mf[0]) return 0;
        if (mf[1]) return 1;
        return -1;
    endfunction

    task automatic model_edge();
        int w;
        w = winner();
        acc_a = !rst && bus.a_valid && (!mf[0] || w == 0);
        acc_b = !rst && bus.b_valid && (!mf[1] || w == 1);
        if (rst) begin
            mf[0] = 0; mf[1] = 0;
            mlast = 1; mwe = 0; mwr = 0; mwd = 0; mcnt = 0;
        end else begin
            if (mf[0] && mf[1] && mcnt < 255) mcnt++;
            if (w >= 0) begin
                mwe = 1; mwr = mr[w]; mwd = md[w]; mlast = (w == 1); mf[w] = 0;
            end else begin
                mwe = 0;
            end
            if (acc_a) begin mf[0] = 1; mr[0] = bus.a_reg; md[0] = bus.a_data; acc_total++; end
            if (acc_b) begin mf[1] = 1; mr[1] = bus.b_reg; md[1] = bus.b_data; acc_total++; end
        end
    endtask

    function automatic logic [17:0] exp_vec();
        logic [3:0] b;
        int w;
        w = winner();
        b = '0;
        for (int r = 0; r < 4; r++)
            b[r] = (mf[0] && mr[0] == 2'(r)) || (mf[1] && mr[1] == 2'(r)) || (mwe && mwr == 2'(r));
        return {mwe, mwr, mwd, mlast, b, (!mf[0] || w == 0), (!mf[1] || w == 1)};
    endfunction

    function automatic logic [17:0] act_vec();
        return {bus.regwrite, bus.writereg, bus.wdata, bus.last_grant, bus.busy, bus.a_ready, bus.b_ready};
    endfunction

    task automatic cycle();
        @(negedge clk);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_checks++;
            if (act_vec() !== exp_vec()) $display("FAIL reset_idle%0d got %h exp %h", i, act_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (act_vec() !== {1'b0, 2'd0, 8'h00, 1'b1, 4'b0000, 1'b1, 1'b1})
            $display("FAIL reset_const got %h exp %h", act_vec(), {1'b0, 2'd0, 8'h00, 1'b1, 4'b0000, 1'b1, 1'b1});
        else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        bus.a_valid = 1'b1; bus.a_reg = 2'd2; bus.a_data = 8'h5A;
        cycle();
        bus.a_valid = 1'b0;
        n_checks++;
        if (bus.busy !== 4'b0100 || bus.regwrite !== 1'b0)
            $display("FAIL single_e1 got busy=%b rw=%b exp busy=0100 rw=0", bus.busy, bus.regwrite);
        else n_pass++;
        cycle();
        n_checks++;
        if ({bus.regwrite, bus.writereg, bus.wdata, bus.last_grant} !== {1'b1, 2'd2, 8'h5A, 1'b0})
            $display("FAIL single_e2 got %b/%0d/%h/%b exp 1/2/5a/0", bus.regwrite, bus.writereg, bus.wdata, bus.last_grant);
        else n_pass++;
        cycle();
        n_checks++;
        if (bus.regwrite !== 1'b0 || bus.busy !== 4'b0000 || act_vec() !== exp_vec())
            $display("FAIL single_e3 got %h exp %h", act_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_tie();
        do_reset();
        bus.a_valid = 1'b1; bus.a_reg = 2'd1; bus.a_data = 8'h11;
        bus.b_valid = 1'b1; bus.b_reg = 2'd3; bus.b_data = 8'h33;
        cycle();
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        n_checks++;
        if ({bus.a_ready, bus.b_ready, bus.busy} !== {1'b1, 1'b0, 4'b1010})
            $display("FAIL tie_ready got a=%b b=%b busy=%b exp a=1 b=0 busy=1010", bus.a_ready, bus.b_ready, bus.busy);
        else n_pass++;
        cycle();
        n_checks++;
        if ({bus.regwrite, bus.writereg, bus.wdata, bus.last_grant} !== {1'b1, 2'd1, 8'h11, 1'b0})
            $display("FAIL tie_first got %b/%0d/%h/%b exp 1/1/11/0", bus.regwrite, bus.writereg, bus.wdata, bus.last_grant);
        else n_pass++;
        cycle();
        n_checks++;
        if ({bus.regwrite, bus.writereg, bus.wdata, bus.last_grant} !== {1'b1, 2'd3, 8'h33, 1'b1})
            $display("FAIL tie_second got %b/%0d/%h/%b exp 1/3/33/1", bus.regwrite, bus.writereg, bus.wdata, bus.last_grant);
        else n_pass++;
`ifdef REGARB_STATS_EN
        n_checks++;
        if (conflict_count !== 8'd1) $display("FAIL tie_conflicts got %0d exp 1", conflict_count);
        else n_pass++;
`endif
        cycle();
        n_checks++;
        if (bus.regwrite !== 1'b0 || bus.busy !== 4'b0000)
            $display("FAIL tie_idle got rw=%b busy=%b exp 0/0000", bus.regwrite, bus.busy);
        else n_pass++;
    endtask

    task automatic test_same_reg();
        do_reset();
        bus.a_valid = 1'b1; bus.a_reg = 2'd2; bus.a_data = 8'h01;
        cycle();
        bus.a_valid = 1'b0;
        cycle();
        cycle();
        bus.a_valid = 1'b1; bus.a_reg = 2'd0; bus.a_data = 8'hAA;
        bus.b_valid = 1'b1; bus.b_reg = 2'd0; bus.b_data = 8'hBB;
        cycle();
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        cycle();
        n_checks++;
        if ({bus.regwrite, bus.writereg, bus.wdata, bus.last_grant} !== {1'b1, 2'd0, 8'hBB, 1'b1})
            $display("FAIL same_first got %b/%0d/%h/%b exp 1/0/bb/1", bus.regwrite, bus.writereg, bus.wdata, bus.last_grant);
        else n_pass++;
        cycle();
        n_checks++;
        if ({bus.regwrite, bus.writereg, bus.wdata, bus.last_grant} !== {1'b1, 2'd0, 8'hAA, 1'b0})
            $display("FAIL same_second got %b/%0d/%h/%b exp 1/0/aa/0", bus.regwrite, bus.writereg, bus.wdata, bus.last_grant);
        else n_pass++;
        cycle();
        n_checks++;
        if (rf_obs[0] !== 8'hAA) $display("FAIL same_final got %h exp aa", rf_obs[0]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int wr0, acc0;
        do_reset();
        wr0 = wr_count; acc0 = acc_total;
        bus.a_valid = 1'b1; bus.a_reg = 2'($urandom); bus.a_data = 8'($urandom);
        bus.b_valid = 1'b1; bus.b_reg = 2'($urandom); bus.b_data = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            cycle();
            n_checks++;
            if (act_vec() !== exp_vec()) $display("FAIL stream%0d got %h exp %h", i, act_vec(), exp_vec());
            else n_pass++;
            if (acc_a) begin bus.a_reg = 2'($urandom); bus.a_data = 8'($urandom); end
            if (acc_b) begin bus.b_reg = 2'($urandom); bus.b_data = 8'($urandom); end
        end
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (act_vec() !== exp_vec()) $display("FAIL drain%0d got %h exp %h", i, act_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (wr_count - wr0 !== acc_total - acc0)
            $display("FAIL stream_count got %0d writes exp %0d", wr_count - wr0, acc_total - acc0);
        else n_pass++;
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        bad = 0;
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!bus.a_valid || acc_a) begin
                bus.a_valid = 1'($urandom_range(0, 1)); bus.a_reg = 2'($urandom); bus.a_data = 8'($urandom);
            end
            if (!bus.b_valid || acc_b) begin
                bus.b_valid = 1'($urandom_range(0, 1)); bus.b_reg = 2'($urandom); bus.b_data = 8'($urandom);
            end
            cycle();
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                if (bad < 10) $display("FAIL random%0d got %h exp %h", i, act_vec(), exp_vec());
            end else n_pass++;
        end
`ifdef REGARB_STATS_EN
        n_checks++;
        if (conflict_count !== 8'(mcnt)) $display("FAIL random_conflicts got %0d exp %0d", conflict_count, mcnt);
        else n_pass++;
`endif
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int wr0;
        do_reset();
        bus.a_valid = 1'b1; bus.a_reg = 2'd1; bus.a_data = 8'h11;
        bus.b_valid = 1'b1; bus.b_reg = 2'd3; bus.b_data = 8'h33;
        cycle();
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        wr0 = wr_count;
        n_checks++;
        if (act_vec() !== {1'b0, 2'd0, 8'h00, 1'b1, 4'b0000, 1'b1, 1'b1})
            $display("FAIL rstmid_state got %h exp %h", act_vec(), {1'b0, 2'd0, 8'h00, 1'b1, 4'b0000, 1'b1, 1'b1});
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (bus.regwrite !== 1'b0 || bus.busy !== 4'b0000 || act_vec() !== exp_vec())
                $display("FAIL rstmid_idle%0d got %h exp %h", i, act_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (wr_count !== wr0) $display("FAIL rstmid_writes got %0d exp %0d", wr_count - wr0, 0);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; acc_total = 0;
        rst = 1'b1;
        bus.a_valid = 1'b0; bus.a_reg = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_reg = '0; bus.b_data = '0;
        test_reset();
        test_single();
        test_tie();
        test_same_reg();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
